// File: rtl/jtkicker_romsrv.sv
// Video ROM line server: one cached 32-bit line per client (scroll/object), misses fetched as two 16-bit beats.
// Define JTKICKER_ROMSRV_TIMEOUT_EN to abort and retry requests that are not acked within TOUT cycles.
module jtkicker_romsrv #(
  parameter logic [21:0] SCR_OFFSET = 22'h0,
  parameter logic [21:0] OBJ_OFFSET = 22'h4000,
  parameter logic [7:0]  TOUT       = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] scr_addr,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  input  logic [12:0] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic        mem_req,
  output logic [21:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rdy,
  input  logic [15:0] mem_data,
  output logic        tout_err
);

  localparam int unsigned AW  = 13;
  localparam int unsigned DW  = 32;
  localparam int unsigned MAW = 22;
  localparam int unsigned CW  = 8;

`ifdef JTKICKER_ROMSRV_TIMEOUT_EN
  localparam bit TOUT_EN = 1'b1;
`else
  localparam bit TOUT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WACK, BEAT0, BEAT1} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_scr_tag, w_scr_tag_nxt, r_obj_tag, w_obj_tag_nxt;
  logic            r_scr_valid, w_scr_valid_nxt, r_obj_valid, w_obj_valid_nxt;
  logic [DW-1:0]   r_scr_data, w_scr_data_nxt, r_obj_data, w_obj_data_nxt;
  logic [AW-1:0]   r_pend_addr, w_pend_addr_nxt;
  logic            r_pend_obj, w_pend_obj_nxt;
  logic            r_prio_obj, w_prio_obj_nxt;
  logic            r_mem_req, w_mem_req_nxt;
  logic [MAW-1:0]  r_mem_addr, w_mem_addr_nxt;
  logic [CW-1:0]   r_tcnt, w_tcnt_nxt;
  logic            r_tout_err, w_tout_err_nxt;

  logic            w_scr_miss, w_obj_miss, w_sel_obj;
  logic [MAW-1:0]  w_scr_maddr, w_obj_maddr;
  logic [CW-1:0]   w_tcnt_inc;

  assign scr_ok   = r_scr_valid & (scr_addr == r_scr_tag);
  assign obj_ok   = r_obj_valid & (obj_addr == r_obj_tag);
  assign scr_data = r_scr_data;
  assign obj_data = r_obj_data;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign tout_err = r_tout_err;

  assign w_scr_miss  = ~scr_ok;
  assign w_obj_miss  = ~obj_ok;
  // r_prio_obj names the client that wins the next simultaneous miss
  assign w_sel_obj   = w_obj_miss & (~w_scr_miss | r_prio_obj);
  assign w_scr_maddr = SCR_OFFSET + MAW'({scr_addr, 1'b0});
  assign w_obj_maddr = OBJ_OFFSET + MAW'({obj_addr, 1'b0});
  assign w_tcnt_inc  = r_tcnt + CW'(1);

  // Next-state and line/port updates
  always_comb begin
    w_state_nxt     = r_state;
    w_scr_tag_nxt   = r_scr_tag;
    w_obj_tag_nxt   = r_obj_tag;
    w_scr_valid_nxt = r_scr_valid;
    w_obj_valid_nxt = r_obj_valid;
    w_scr_data_nxt  = r_scr_data;
    w_obj_data_nxt  = r_obj_data;
    w_pend_addr_nxt = r_pend_addr;
    w_pend_obj_nxt  = r_pend_obj;
    w_prio_obj_nxt  = r_prio_obj;
    w_mem_req_nxt   = r_mem_req;
    w_mem_addr_nxt  = r_mem_addr;
    w_tcnt_nxt      = r_tcnt;
    w_tout_err_nxt  = r_tout_err;
    case (r_state)
      IDLE: begin
        if (w_scr_miss | w_obj_miss) begin
          if (w_scr_miss & w_obj_miss) w_prio_obj_nxt = ~w_sel_obj;
          w_pend_obj_nxt  = w_sel_obj;
          w_pend_addr_nxt = w_sel_obj ? obj_addr : scr_addr;
          w_mem_addr_nxt  = w_sel_obj ? w_obj_maddr : w_scr_maddr;
          w_mem_req_nxt   = 1'b1;
          if (w_sel_obj) w_obj_valid_nxt = 1'b0;
          else           w_scr_valid_nxt = 1'b0;
          w_tcnt_nxt      = '0;
          w_state_nxt     = WACK;
        end
      end
      WACK: begin
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = BEAT0;
        end else begin
          w_tcnt_nxt = w_tcnt_inc;
          // abandoned request leaves the line invalid, so IDLE reissues it
          if (TOUT_EN && (w_tcnt_inc == TOUT)) begin
            w_mem_req_nxt  = 1'b0;
            w_tout_err_nxt = 1'b1;
            w_state_nxt    = IDLE;
          end
        end
      end
      BEAT0: begin
        if (mem_rdy) begin
          if (r_pend_obj) w_obj_data_nxt = {r_obj_data[31:16], mem_data};
          else            w_scr_data_nxt = {r_scr_data[31:16], mem_data};
          w_state_nxt = BEAT1;
        end
      end
      BEAT1: begin
        if (mem_rdy) begin
          if (r_pend_obj) begin
            w_obj_data_nxt  = {mem_data, r_obj_data[15:0]};
            w_obj_tag_nxt   = r_pend_addr;
            w_obj_valid_nxt = 1'b1;
          end else begin
            w_scr_data_nxt  = {mem_data, r_scr_data[15:0]};
            w_scr_tag_nxt   = r_pend_addr;
            w_scr_valid_nxt = 1'b1;
          end
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_scr_tag   <= '0;
      r_obj_tag   <= '0;
      r_scr_valid <= 1'b0;
      r_obj_valid <= 1'b0;
      r_scr_data  <= '0;
      r_obj_data  <= '0;
      r_pend_addr <= '0;
      r_pend_obj  <= 1'b0;
      r_prio_obj  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_tcnt      <= '0;
      r_tout_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_scr_tag   <= w_scr_tag_nxt;
      r_obj_tag   <= w_obj_tag_nxt;
      r_scr_valid <= w_scr_valid_nxt;
      r_obj_valid <= w_obj_valid_nxt;
      r_scr_data  <= w_scr_data_nxt;
      r_obj_data  <= w_obj_data_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_pend_obj  <= w_pend_obj_nxt;
      r_prio_obj  <= w_prio_obj_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_tout_err  <= w_tout_err_nxt;
    end
  end

endmodule

// File: tb/tb_jtkicker_romsrv.sv
// Self-checking bench for jtkicker_romsrv: directed scenarios plus randomized traffic against a cache/arbiter model.
module tb_jtkicker_romsrv;

  localparam logic [21:0] SCR_OFF = 22'h0;
  localparam logic [21:0] OBJ_OFF = 22'h4000;
  localparam int          TOUT_T  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] scr_addr, obj_addr;
  logic [31:0] scr_data, obj_data;
  logic        scr_ok, obj_ok;
  logic        mem_req, mem_ack, mem_rdy, tout_err;
  logic [21:0] mem_addr;
  logic [15:0] mem_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtkicker_romsrv #(
    .SCR_OFFSET(SCR_OFF),
    .OBJ_OFFSET(OBJ_OFF),
    .TOUT      (8'(TOUT_T))
  ) dut (
    .clk(clk), .rst(rst),
    .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdy(mem_rdy), .mem_data(mem_data), .tout_err(tout_err)
  );

  // Synthetic SDRAM contents
  function automatic logic [15:0] memval(input logic [21:0] a);
    return a[15:0] ^ {a[21:16], a[9:0]} ^ 16'h3C5A;
  endfunction

  task automatic wait_req(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Called at a negedge with mem_req high; returns one negedge after the ack edge.
  task automatic do_ack(input int dly, output bit held);
    held = 1'b1;
    repeat (dly) begin
      @(negedge clk);
      if (mem_req !== 1'b1) held = 1'b0;
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic do_beats(input int gap, input logic [15:0] lo, input logic [15:0] hi);
    mem_data = 16'($urandom);
    repeat (gap) @(negedge clk);
    mem_rdy = 1'b1; mem_data = lo;
    @(negedge clk);
    mem_rdy = 1'b0; mem_data = 16'($urandom);
    repeat (gap) @(negedge clk);
    mem_rdy = 1'b1; mem_data = hi;
    @(negedge clk);
    mem_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_rdy = 1'b0; mem_data = '0;
    scr_addr = 13'h0005; obj_addr = 13'h0000;
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 22'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (scr_data !== 32'h0) begin n_err++; $display("FAIL reset_scr_data: got %h want 0", scr_data); end
    n_cmp++; if (obj_data !== 32'h0) begin n_err++; $display("FAIL reset_obj_data: got %h want 0", obj_data); end
    n_cmp++; if (tout_err !== 1'b0) begin n_err++; $display("FAIL reset_tout_err: got %b want 0", tout_err); end
    n_cmp++; if (scr_ok !== 1'b0) begin n_err++; $display("FAIL reset_scr_ok: got %b want 0", scr_ok); end
    n_cmp++; if (obj_ok !== 1'b0) begin n_err++; $display("FAIL reset_obj_ok (addr equals cleared tag): got %b want 0", obj_ok); end
    rst = 1'b0;
  endtask

  task automatic test_single_scr();
    bit got, held;
    wait_req(20, got);
    n_cmp++; if (!got) begin n_err++; $display("FAIL single_req: got none want mem_req"); end
    n_cmp++; if (mem_addr !== 22'h00000A) begin n_err++; $display("FAIL single_addr: got %h want 00000a", mem_addr); end
    do_ack(3, held);
    n_cmp++; if (!held) begin n_err++; $display("FAIL single_req_held: got dropped want held until ack"); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL single_req_drop: got %b want 0", mem_req); end
    do_beats(0, 16'h1234, 16'h5678);
    n_cmp++; if (scr_ok !== 1'b1) begin n_err++; $display("FAIL single_scr_ok: got %b want 1", scr_ok); end
    n_cmp++; if (scr_data !== 32'h56781234) begin n_err++; $display("FAIL single_scr_data: got %h want 56781234", scr_data); end
    n_cmp++; if (obj_ok !== 1'b0) begin n_err++; $display("FAIL single_obj_ok: got %b want 0", obj_ok); end
    // object line (addr 0) still misses and is served next
    wait_req(20, got);
    n_cmp++; if (!got || mem_addr !== 22'h004000) begin n_err++; $display("FAIL single_obj_addr: got %h (req %b) want 004000", mem_addr, got); end
    do_ack(0, held);
    do_beats(1, memval(22'h004000), memval(22'h004001));
    n_cmp++; if (obj_ok !== 1'b1 || obj_data !== {memval(22'h004001), memval(22'h004000)}) begin
      n_err++; $display("FAIL single_obj_fill: got ok=%b data=%h want ok=1 data=%h", obj_ok, obj_data, {memval(22'h004001), memval(22'h004000)});
    end
  endtask

  task automatic test_hit_change();
    bit got, held, quiet;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || scr_ok !== 1'b1) quiet = 1'b0;
    end
    n_cmp++; if (!quiet) begin n_err++; $display("FAIL hit_quiet: got req=%b ok=%b want req=0 ok=1", mem_req, scr_ok); end
    scr_addr = 13'h0006;
    #1;
    n_cmp++; if (scr_ok !== 1'b0) begin n_err++; $display("FAIL change_ok_same_cycle: got %b want 0", scr_ok); end
    wait_req(20, got);
    n_cmp++; if (!got || mem_addr !== 22'h00000C) begin n_err++; $display("FAIL change_addr: got %h (req %b) want 00000c", mem_addr, got); end
    do_ack(0, held);
    do_beats(0, memval(22'h00000C), memval(22'h00000D));
    n_cmp++; if (scr_ok !== 1'b1 || scr_data !== {memval(22'h00000D), memval(22'h00000C)}) begin
      n_err++; $display("FAIL change_fill: got ok=%b data=%h want ok=1", scr_ok, scr_data);
    end
  endtask

  task automatic test_simultaneous();
    bit got, held;
    rst = 1'b1; scr_addr = 13'h0001; obj_addr = 13'h0002;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_req(20, got);
    n_cmp++; if (!got || mem_addr !== 22'h000002) begin n_err++; $display("FAIL simul_first: got %h want 000002", mem_addr); end
    do_ack(1, held); do_beats(0, memval(22'h000002), memval(22'h000003));
    wait_req(20, got);
    n_cmp++; if (!got || mem_addr !== 22'h004004) begin n_err++; $display("FAIL simul_second: got %h want 004004", mem_addr); end
    do_ack(0, held); do_beats(0, memval(22'h004004), memval(22'h004005));
    n_cmp++; if (scr_ok !== 1'b1 || obj_ok !== 1'b1) begin n_err++; $display("FAIL simul_both_ok: got %b%b want 11", scr_ok, obj_ok); end
    scr_addr = 13'h0007; obj_addr = 13'h0009;
    wait_req(20, got);
    n_cmp++; if (!got || mem_addr !== 22'h004012) begin n_err++; $display("FAIL simul_rr_obj_first: got %h want 004012", mem_addr); end
    do_ack(0, held); do_beats(0, memval(22'h004012), memval(22'h004013));
    n_cmp++; if (obj_ok !== 1'b1 || scr_ok !== 1'b0) begin n_err++; $display("FAIL simul_rr_oks: got obj=%b scr=%b want 1 0", obj_ok, scr_ok); end
    wait_req(20, got);
    n_cmp++; if (!got || mem_addr !== 22'h00000E) begin n_err++; $display("FAIL simul_rr_scr_second: got %h want 00000e", mem_addr); end
    do_ack(0, held); do_beats(0, memval(22'h00000E), memval(22'h00000F));
    n_cmp++; if (scr_data !== {memval(22'h00000F), memval(22'h00000E)} || obj_data !== {memval(22'h004013), memval(22'h004012)}) begin
      n_err++; $display("FAIL simul_rr_data: got scr=%h obj=%h", scr_data, obj_data);
    end
  endtask

  task automatic test_midfetch();
    bit got, held;
    obj_addr = 13'h0003;
    wait_req(20, got);
    n_cmp++; if (!got || mem_addr !== 22'h004006) begin n_err++; $display("FAIL mid_first_addr: got %h want 004006", mem_addr); end
    do_ack(1, held);
    obj_addr = 13'h0004;
    n_cmp++; if (scr_ok !== 1'b1) begin n_err++; $display("FAIL mid_other_ok: got %b want 1", scr_ok); end
    do_beats(0, memval(22'h004006), memval(22'h004007));
    n_cmp++; if (obj_ok !== 1'b0) begin n_err++; $display("FAIL mid_stale_ok: got %b want 0", obj_ok); end
    wait_req(20, got);
    n_cmp++; if (!got || mem_addr !== 22'h004008) begin n_err++; $display("FAIL mid_refetch_addr: got %h want 004008", mem_addr); end
    n_cmp++; if (obj_ok !== 1'b0) begin n_err++; $display("FAIL mid_ok_before_beats: got %b want 0", obj_ok); end
    do_ack(0, held); do_beats(2, memval(22'h004008), memval(22'h004009));
    n_cmp++; if (obj_ok !== 1'b1 || obj_data !== {memval(22'h004009), memval(22'h004008)}) begin
      n_err++; $display("FAIL mid_refetch_fill: got ok=%b data=%h", obj_ok, obj_data);
    end
  endtask

  task automatic test_reset_midbeat();
    bit got, held;
    scr_addr = 13'h1ABC;
    wait_req(20, got);
    do_ack(0, held);
    mem_rdy = 1'b1; mem_data = 16'hBEEF; rst = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 22'h0 || scr_ok !== 1'b0 || obj_ok !== 1'b0 || obj_data !== 32'h0) begin
      n_err++; $display("FAIL rst_mid: got req=%b addr=%h ok=%b%b obj=%h want all 0", mem_req, mem_addr, scr_ok, obj_ok, obj_data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mem_rdy = 1'b0;
    n_cmp++; if (scr_data !== 32'h0 || obj_data !== 32'h0) begin
      n_err++; $display("FAIL rst_stray_rdy: got scr=%h obj=%h want 0 0", scr_data, obj_data);
    end
    wait_req(20, got);
    n_cmp++; if (!got || mem_addr !== 22'h003578) begin n_err++; $display("FAIL rst_refetch: got %h want 003578", mem_addr); end
    do_ack(0, held); do_beats(0, memval(22'h003578), memval(22'h003579));
    wait_req(20, got);
    do_ack(0, held); do_beats(0, memval(22'h004008), memval(22'h004009));
    n_cmp++; if (scr_ok !== 1'b1 || obj_ok !== 1'b1) begin n_err++; $display("FAIL rst_recover_oks: got %b%b want 11", scr_ok, obj_ok); end
  endtask

  task automatic test_timeout();
    bit got, held;
    int cnt;
    scr_addr = 13'h0ABC;
    wait_req(20, got);
    n_cmp++; if (!got || mem_addr !== 22'h001578) begin n_err++; $display("FAIL tout_addr: got %h want 001578", mem_addr); end
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b1) break;
      cnt++;
    end
`ifdef JTKICKER_ROMSRV_TIMEOUT_EN
    n_cmp++; if (cnt != TOUT_T || tout_err !== 1'b1) begin
      n_err++; $display("FAIL tout_drop: got %0d req cycles err=%b want %0d err=1", cnt, tout_err, TOUT_T);
    end
    wait_req(20, got);
    n_cmp++; if (!got || mem_addr !== 22'h001578 || tout_err !== 1'b1) begin
      n_err++; $display("FAIL tout_retry: got req=%b addr=%h err=%b want 1 001578 1", got, mem_addr, tout_err);
    end
`else
    n_cmp++; if (cnt != 41 || tout_err !== 1'b0) begin
      n_err++; $display("FAIL tout_wait: got %0d req cycles err=%b want 41 err=0", cnt, tout_err);
    end
`endif
    do_ack(0, held); do_beats(0, memval(22'h001578), memval(22'h001579));
    n_cmp++; if (scr_ok !== 1'b1 || scr_data !== {memval(22'h001579), memval(22'h001578)}) begin
      n_err++; $display("FAIL tout_fill: got ok=%b data=%h", scr_ok, scr_data);
    end
  endtask

  // Model: per-client {valid, tag, data}; a simultaneous miss goes to the preferred client,
  // after which the other client becomes preferred. Scroll is preferred out of reset.
  task automatic test_random();
    bit got, held, quiet, prio_obj, miss0, miss1, exp_ok;
    bit          m_valid [2];
    logic [12:0] m_tag   [2];
    logic [31:0] m_data  [2];
    logic [21:0] off     [2];
    logic [12:0] caddr, oaddr;
    logic [21:0] exp_a;
    logic [15:0] lo, hi;
    int sel, c;
    off[0] = SCR_OFF; off[1] = OBJ_OFF;
    m_valid[0] = 1'b0; m_valid[1] = 1'b0; prio_obj = 1'b0;
    m_tag[0] = '0; m_tag[1] = '0; m_data[0] = '0; m_data[1] = '0;
    rst = 1'b1; scr_addr = 13'($urandom); obj_addr = 13'($urandom);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int it = 0; it < 30; it++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0 || sel == 2) scr_addr = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, 7));
      if (sel == 1 || sel == 2) obj_addr = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) begin
        miss0 = !(m_valid[0] && m_tag[0] == scr_addr);
        miss1 = !(m_valid[1] && m_tag[1] == obj_addr);
        if (!miss0 && !miss1) begin
          quiet = 1'b1;
          repeat (2) begin @(negedge clk); if (mem_req !== 1'b0) quiet = 1'b0; end
          n_cmp++; if (!quiet || scr_ok !== 1'b1 || obj_ok !== 1'b1 || scr_data !== m_data[0] || obj_data !== m_data[1]) begin
            n_err++; $display("FAIL rand_hit it=%0d: got req_quiet=%b ok=%b%b scr=%h obj=%h want 1 11 %h %h",
                              it, quiet, scr_ok, obj_ok, scr_data, obj_data, m_data[0], m_data[1]);
          end
          break;
        end
        c = (miss1 && (!miss0 || prio_obj)) ? 1 : 0;
        if (miss0 && miss1) prio_obj = (c == 0);
        caddr = (c == 1) ? obj_addr : scr_addr;
        oaddr = (c == 1) ? scr_addr : obj_addr;
        exp_a = off[c] + 22'({caddr, 1'b0});
        wait_req(20, got);
        n_cmp++; if (!got || mem_addr !== exp_a) begin
          n_err++; $display("FAIL rand_req it=%0d: got req=%b addr=%h want %h", it, got, mem_addr, exp_a);
        end
        if (!got) break;
        m_valid[c] = 1'b0;
        do_ack(int'($urandom_range(0, 3)), held);
        exp_ok = m_valid[1-c] && (m_tag[1-c] == oaddr);
        n_cmp++; if (!held || ((c == 1) ? scr_ok : obj_ok) !== exp_ok) begin
          n_err++; $display("FAIL rand_during it=%0d: got held=%b other_ok=%b want 1 %b", it, held, (c == 1) ? scr_ok : obj_ok, exp_ok);
        end
        lo = memval(exp_a); hi = memval(exp_a + 22'd1);
        do_beats(int'($urandom_range(0, 2)), lo, hi);
        m_valid[c] = 1'b1; m_tag[c] = caddr; m_data[c] = {hi, lo};
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_scr();
    test_hit_change();
    test_simultaneous();
    test_midfetch();
    test_reset_midbeat();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
